// File: rtl/debounce_pkg.sv
// Shared defaults and elaboration-time helpers for the multi-channel button debouncer.
package debounce_pkg;

  localparam int DEF_N_CH     = 5;
  localparam int DEF_CNT_W    = 12;
  localparam int DEF_TH_HI    = 2000;
  localparam int DEF_TH_LO    = 1000;
  localparam int DEF_LONG_CYC = 50000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Thresholds must sit strictly inside the counter range so both edges of the window are reachable.
  function automatic bit params_ok(input int cnt_w, input int th_hi, input int th_lo,
                                   input int long_cyc);
    longint cnt_max;
    cnt_max = (64'sd1 <<< cnt_w) - 64'sd1;
    return (th_lo >= 1) && (th_lo <= th_hi) && (longint'(th_hi) < cnt_max) && (long_cyc >= 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: two-flop synchroniser, saturating integrator, hysteresis level,
// edge pulses and a single long-press pulse per press.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TH_HI    = DEF_TH_HI,
  parameter int TH_LO    = DEF_TH_LO,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_press_o
);

  localparam int HOLD_W = clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  HI       = CNT_W'(TH_HI);
  localparam logic [CNT_W-1:0]  LO       = CNT_W'(TH_LO);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYC - 1);

  logic              ff1_q, ff2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              rise_q, fall_q, long_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ff2_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    // Between the two thresholds the previous level is kept.
    level_d = level_q;
    if (cnt_q > HI)      level_d = 1'b1;
    else if (cnt_q < LO) level_d = 1'b0;

    hold_d = '0;
    if (level_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q   <= 1'b0;
      ff2_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      ff1_q   <= btn_i;
      ff2_q   <= ff1_q;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      // hold_q passes LONG_CYC-1 exactly once while level stays high.
      long_q  <= level_q && (hold_q == HOLD_PRE);
    end
  end

  assign level_o      = level_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent button debouncers; rejects inconsistent threshold settings at elaboration.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TH_HI    = DEF_TH_HI,
  parameter int TH_LO    = DEF_TH_LO,
  parameter int LONG_CYC = DEF_LONG_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  if (!params_ok(CNT_W, TH_HI, TH_LO, LONG_CYC)) begin : g_param_err
    $fatal(1, "debounce_multi: need 1 <= TH_LO <= TH_HI < 2**CNT_W-1 and LONG_CYC >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_chan #(
      .CNT_W   (CNT_W),
      .TH_HI   (TH_HI),
      .TH_LO   (TH_LO),
      .LONG_CYC(LONG_CYC)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_i       (btn[i]),
      .level_o     (level[i]),
      .rise_o      (rise[i]),
      .fall_o      (fall[i]),
      .long_press_o(long_press[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboarded directed test of debounce_multi with small thresholds (N_CH=2, CNT_W=4, 8/4, LONG_CYC=6).
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] level, rise, fall, long_press;

  debounce_multi #(
    .N_CH(2), .CNT_W(4), .TH_HI(8), .TH_LO(4), .LONG_CYC(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lv;
    logic [1:0] rs;
    logic [1:0] fl;
    logic [1:0] lp;
    int         tid;
    int         en;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  function automatic string tname(input int tid);
    case (tid)
      0:       return "reset";
      1:       return "press";
      2:       return "glitch";
      3:       return "release";
      4:       return "hysteresis";
      5:       return "reset_mid_press";
      6:       return "independence";
      default: return "other";
    endcase
  endfunction

  task automatic chk(input string nm, input exp_t e, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s edge=%0d got=%b expected=%b", tname(e.tid), nm, e.en, got, want);
    end
  endtask

  // Monitor: every clock the DUT presents a fresh output vector, checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("level", e, level, e.lv);
        chk("rise",  e, rise,  e.rs);
        chk("fall",  e, fall,  e.fl);
        chk("long",  e, long_press, e.lp);
      end
    end
  end

  task automatic cyc(input int tid, input logic [1:0] b, input logic r,
                     input logic [1:0] lv, input logic [1:0] rs,
                     input logic [1:0] fl, input logic [1:0] lp);
    exp_t e;
    @(negedge clk);
    btn = b;
    rst = r;
    edge_n++;
    e.lv = lv; e.rs = rs; e.fl = fl; e.lp = lp; e.tid = tid; e.en = edge_n;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b00;

    // Reset state
    cyc(0, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Press: level on edge 12, long press 6 edges later, count saturates
    for (int k = 1; k <= 30; k++)
      cyc(1, 2'b01, 1'b0, {1'b0, k >= 12}, {1'b0, k == 12}, 2'b00, {1'b0, k == 18});

    // Release from saturated count 15: level drops on edge 15
    for (int k = 1; k <= 20; k++)
      cyc(3, 2'b00, 1'b0, {1'b0, k < 15}, 2'b00, {1'b0, k == 15}, 2'b00);

    // Glitch of 5 cycles never crosses TH_HI
    for (int k = 1; k <= 20; k++)
      cyc(2, (k <= 5) ? 2'b01 : 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Hysteresis: saturate, dip to count 6, press again
    for (int k = 1; k <= 20; k++)
      cyc(4, 2'b01, 1'b0, {1'b0, k >= 12}, {1'b0, k == 12}, 2'b00, {1'b0, k == 18});
    for (int k = 1; k <= 9; k++)
      cyc(4, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 15; k++)
      cyc(4, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);

    // Reset mid-press: no fall, fresh debounce afterwards
    cyc(5, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 14; k++)
      cyc(5, 2'b01, 1'b0, {1'b0, k >= 12}, {1'b0, k == 12}, 2'b00, 2'b00);
    cyc(5, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 3; k++)
      cyc(5, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Independence: channel 1 pressed 3 cycles after channel 0
    for (int k = 1; k <= 24; k++)
      cyc(6, {k >= 4, 1'b1}, 1'b0,
          {k >= 15, k >= 12}, {k == 15, k == 12}, 2'b00, {k == 21, k == 18});
    cyc(6, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(6, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
